// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped data cache controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ,
    FILL
  } state_t;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  // Helpers work on a 64-bit carrier so any ADDR_W up to 64 can use them.
  function automatic logic [63:0] line_index(input logic [63:0] addr, input int unsigned idx_w);
    return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] addr, input int unsigned idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/dcache_perf_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module dcache_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_ctrl.sv
// Miss / write-through sequencer between the load-store stage, the direct-mapped
// cache array and a multi-cycle data memory.
module dcache_ctrl import dcache_pkg::*; #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int LINES  = 8,
  parameter  int CNT_W  = 32,
  localparam int IDX_W  = $clog2(LINES),
  localparam int TAG_W  = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_funct3,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [IDX_W-1:0]  arr_index,
  output logic [TAG_W-1:0]  arr_tag,
  input  logic              arr_hit,
  input  logic [DATA_W-1:0] arr_rdata,
  output logic              arr_fill_we,
  output logic              arr_upd_we,
  output logic [DATA_W-1:0] arr_wdata,
  output logic              arr_inv_all,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;
  logic [2:0]        funct3_q;
  logic              hit_q;

  logic load, store, idle_hit, idle_miss;

  // A store takes priority when the CPU raises both request lines.
  assign store     = cpu_we;
  assign load      = cpu_re && !cpu_we;
  assign idle_hit  = (state_q == IDLE) && load && arr_hit;
  assign idle_miss = (state_q == IDLE) && load && !arr_hit;

  assign arr_index = IDX_W'(line_index(64'(cpu_addr), IDX_W));
  assign arr_tag   = TAG_W'(line_tag(64'(cpu_addr), IDX_W));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (store) state_d = WR_REQ;
               else if (load && !arr_hit) state_d = RD_REQ;
      RD_REQ:  if (mem_ack) state_d = FILL;
      FILL:    state_d = IDLE;
      WR_REQ:  if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches: captured on acceptance in IDLE, held while memory works.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      fill_q   <= '0;
      funct3_q <= '0;
      hit_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (store) begin
        addr_q   <= cpu_addr;
        wdata_q  <= cpu_wdata;
        funct3_q <= cpu_funct3;
        hit_q    <= arr_hit;
      end else if (load && !arr_hit) begin
        addr_q   <= {cpu_addr[ADDR_W-1:2], 2'b00};
        funct3_q <= cpu_funct3;
        hit_q    <= 1'b0;
      end
    end else if (state_q == RD_REQ && mem_ack) begin
      fill_q <= mem_rdata;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stall       = 1'b0;
    cpu_rdata   = '0;
    arr_fill_we = 1'b0;
    arr_upd_we  = 1'b0;
    arr_wdata   = wdata_q;
    arr_inv_all = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (store) stall = 1'b1;
        else if (load) begin
          if (arr_hit) cpu_rdata = arr_rdata;
          else         stall     = 1'b1;
        end else begin
          arr_inv_all = flush;
        end
      end
      RD_REQ: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      WR_REQ: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        stall      = !mem_ack;
        arr_upd_we = mem_ack && hit_q;
      end
      FILL: begin
        arr_fill_we = 1'b1;
        arr_wdata   = fill_q;
        cpu_rdata   = fill_q;
      end
      default: ;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;

  dcache_perf_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (idle_hit),
    .cnt_o (hit_cnt)
  );

  dcache_perf_cnt #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (idle_miss),
    .cnt_o (miss_cnt)
  );

endmodule
